// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: time-multiplexed LED matrix scanner.
// It keeps a pulse-stretch counter per LED and scans one row per dwell period.
// Each row starts with a blanking cycle. Columns are brightness-modulated with PWM.
// All outputs are registered and lag the internal scan state by one cycle.
module led_scan_ctrl #(
  parameter int ROWS  = 4,
  parameter int COLS  = 8,
  parameter int DWELL = 64,
  parameter int HOLD  = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ROWS*COLS-1:0] act,
  input  logic [3:0]           bright,
  input  logic                 test,
  output logic [ROWS-1:0]      row_n,
  output logic [COLS-1:0]      col,
  output logic                 frame
);

  localparam int N  = ROWS * COLS;
  localparam int CW = $clog2(HOLD + 1);
  localparam int DW = $clog2(DWELL);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [CW-1:0]   stretch [N];
  logic [DW-1:0]   d;
  logic [RW-1:0]   r;
  logic [3:0]      bright_q;
  logic [N-1:0]    lit;
  logic [COLS-1:0] row_lit;
  logic            pwm_on;
  logic            d_last;
  logic            r_last;
  logic            blank;

  // An LED is lit while its stretch counter is running, or when lamp test is on.
  always_comb begin
    lit = '0;
    for (int i = 0; i < N; i++) begin
      lit[i] = (stretch[i] != '0) | test;
    end
  end

  // Select the lit pattern of the row currently being scanned.
  always_comb begin
    row_lit = '0;
    for (int k = 0; k < ROWS; k++) begin
      if (r == RW'(k)) begin
        row_lit = lit[k*COLS +: COLS];
      end
    end
  end

  // Derive the scan position flags and the PWM gate from the 16-cycle window.
  always_comb begin
    d_last = (d == DW'(DWELL - 1));
    r_last = (r == RW'(ROWS - 1));
    blank  = (d == '0);
    pwm_on = (bright_q == 4'hF) | (d[3:0] < bright_q);
  end

  // Per-LED stretch counters: a strobe reloads HOLD; otherwise decay toward zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        stretch[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (act[i]) begin
          stretch[i] <= CW'(HOLD);
        end else if (stretch[i] != '0) begin
          stretch[i] <= stretch[i] - CW'(1);
        end
      end
    end
  end

  // Advance the dwell counter and the row index, and latch brightness at each row start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d        <= '0;
      r        <= '0;
      bright_q <= '0;
    end else begin
      d <= d + DW'(1);
      if (d_last) begin
        r <= r_last ? '0 : r + RW'(1);
      end
      if (blank) begin
        bright_q <= bright;
      end
    end
  end

  // Register the drive outputs. Row changes get a full blanking cycle to avoid ghosting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_n <= '1;
      col   <= '0;
      frame <= 1'b0;
    end else begin
      frame <= d_last & r_last;
      if (blank) begin
        row_n <= '1;
        col   <= '0;
      end else begin
        row_n <= ~(ROWS'(1) << r);
        col   <= row_lit & {COLS{pwm_on}};
      end
    end
  end

endmodule
